// File: rtl/snoop_bus_arbiter_pkg.sv
// snoop_pkg: bus message codes, cache state codes and arbiter FSM states
package snoop_pkg;
  typedef enum logic [2:0] {
    BUS_NONE    = 3'b000,
    BUS_RD_MISS = 3'b001,
    BUS_WR_MISS = 3'b010,
    BUS_INVAL   = 3'b011
  } bus_msg_e;
  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10
  } cache_state_e;
  typedef enum logic [2:0] {IDLE, OWN_WB, BCAST, SNOOP, REMOTE_WB, FILL, DONE} arb_state_e;
  function automatic logic msg_legal(input logic [2:0] m);
    return m == BUS_RD_MISS || m == BUS_WR_MISS || m == BUS_INVAL;
  endfunction
endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// snoop_bus_arbiter_if: processor, snoop and memory signals of the shared snooping bus
interface snoop_bus_arbiter_if #(parameter int N_PROC = 4);
  logic [N_PROC-1:0]   req, req_wb, gnt, snoop_ack, snoop_wb, done;
  logic [3*N_PROC-1:0] req_msg;
  logic                bus_valid, mem_req, mem_we, mem_done, err;
  logic [2:0]          bus_msg;
  logic [1:0]          bus_owner;
  modport master (
    input  req, req_msg, req_wb, snoop_ack, snoop_wb, mem_done,
    output gnt, bus_valid, bus_msg, bus_owner, mem_req, mem_we, done, err
  );
  modport slave (
    output req, req_msg, req_wb, snoop_ack, snoop_wb, mem_done,
    input  gnt, bus_valid, bus_msg, bus_owner, mem_req, mem_we, done, err
  );
endinterface

// File: rtl/snoop_bus_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting after the last owner
module rr_arbiter #(parameter int N = 4) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx,
  output logic         any
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  always_comb begin
    gnt = '0;
    idx = '0;
    // walk the search order backwards so the closest requester overwrites the rest
    for (int k = N; k >= 1; k--) begin
      if (|(req & (ONE << ((int'(last) + k) % N)))) begin
        gnt = ONE << ((int'(last) + k) % N);
        idx = 2'((int'(last) + k) % N);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin snooping bus arbiter and transaction sequencer
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int N_PROC        = 4,
  parameter int SNOOP_TIMEOUT = 15
) (
  input logic                 clock,
  input logic                 reset_n,
  snoop_bus_arbiter_if.master bus
);
  arb_state_e        state_q, state_d;
  logic [N_PROC-1:0] gnt_q, gnt_d, done_q, done_d, ack_q, ack_d, pick_gnt, acks;
  logic [1:0]        owner_q, owner_d, last_q, last_d, bus_owner_q, bus_owner_d, pick_idx;
  logic [2:0]        msg_q, msg_d, bus_msg_q, bus_msg_d, pick_msg;
  logic [7:0]        timer_q, timer_d;
  logic              wb_seen_q, wb_seen_d, bus_valid_q, bus_valid_d, mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d, err_q, err_d;
  logic              pick_any, pick_wb, mem_hit, all_ack, seen, timeout;

  rr_arbiter #(.N(N_PROC)) u_rr (
    .req(bus.req),
    .last(last_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign pick_msg = 3'(bus.req_msg >> (3 * pick_idx));
  assign pick_wb  = |(bus.req_wb & pick_gnt);
  assign mem_hit  = mem_req_q & bus.mem_done;
  // gnt_q is the owner mask for the whole transaction; the owner never acks itself
  assign acks     = ack_q | (bus.snoop_ack & ~gnt_q);
  assign all_ack  = &(acks | gnt_q);
  assign seen     = wb_seen_q | |(bus.snoop_ack & bus.snoop_wb & ~gnt_q);
  assign timeout  = 9'(timer_q) + 9'd1 == 9'(SNOOP_TIMEOUT);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    msg_d     = msg_q;
    ack_d     = ack_q;
    wb_seen_d = wb_seen_q;
    timer_d   = timer_q;
    last_d    = last_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (pick_any) begin
        gnt_d   = pick_gnt;
        owner_d = pick_idx;
        msg_d   = pick_msg;
        state_d = pick_wb ? OWN_WB : msg_legal(pick_msg) ? BCAST : DONE;
        err_d   = !pick_wb && !msg_legal(pick_msg);
      end
      OWN_WB: if (mem_hit) begin
        state_d = msg_legal(msg_q) ? BCAST : DONE;
        err_d   = !msg_legal(msg_q);
      end
      BCAST: begin
        state_d   = SNOOP;
        ack_d     = '0;
        wb_seen_d = 1'b0;
        timer_d   = '0;
      end
      SNOOP: begin
        ack_d     = acks;
        wb_seen_d = seen;
        timer_d   = timer_q + 8'd1;
        if (all_ack || timeout) begin
          state_d = seen ? REMOTE_WB : msg_q == BUS_INVAL ? DONE : FILL;
          err_d   = !all_ack;
        end
      end
      REMOTE_WB: state_d = mem_hit ? FILL : REMOTE_WB;
      FILL:      state_d = mem_hit ? DONE : FILL;
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
    bus_valid_d = state_d == BCAST;
    bus_msg_d   = state_d == BCAST ? msg_d : BUS_NONE;
    bus_owner_d = state_d == IDLE ? 2'd0 : owner_d;
    mem_req_d   = state_d == OWN_WB || state_d == REMOTE_WB || state_d == FILL;
    mem_we_d    = state_d == OWN_WB || state_d == REMOTE_WB;
    done_d      = state_d == DONE ? gnt_d : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      msg_q       <= BUS_NONE;
      ack_q       <= '0;
      wb_seen_q   <= 1'b0;
      timer_q     <= '0;
      last_q      <= 2'(N_PROC - 1);
      bus_valid_q <= 1'b0;
      bus_msg_q   <= BUS_NONE;
      bus_owner_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      msg_q       <= msg_d;
      ack_q       <= ack_d;
      wb_seen_q   <= wb_seen_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      bus_valid_q <= bus_valid_d;
      bus_msg_q   <= bus_msg_d;
      bus_owner_q <= bus_owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_msg   = bus_msg_q;
  assign bus.bus_owner = bus_owner_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed scenario bench for the snooping bus arbiter
module tb_snoop_bus_arbiter;
  localparam int TO = 6;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int w_valid, w_nmem, w_dcyc, w_err, w_ecyc;
  logic [2:0] w_msg;
  logic [1:0] w_own;
  logic [3:0] w_gnt, w_first, w_done;
  logic [7:0] w_we;

  snoop_bus_arbiter_if #(.N_PROC(4)) bus ();
  snoop_bus_arbiter #(.N_PROC(4), .SNOOP_TIMEOUT(TO)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.master)
  );

  always #5 clock = ~clock;

  // observe one transaction cycle by cycle until done pulses or the budget runs out
  task automatic watch(input int max);
    w_valid = 0; w_nmem = 0; w_dcyc = 0; w_err = 0; w_ecyc = 0;
    w_msg = '0; w_own = '0; w_gnt = '0; w_first = '0; w_done = '0; w_we = '0;
    for (int c = 1; c <= max; c++) begin
      @(negedge clock);
      if (c == 1) w_first = bus.gnt;
      if (bus.gnt != 0) w_gnt = bus.gnt;
      if (bus.bus_valid) begin w_valid++; w_msg = bus.bus_msg; w_own = bus.bus_owner; end
      if (bus.mem_req && bus.mem_done) begin w_nmem++; w_we = {w_we[6:0], bus.mem_we}; end
      if (bus.err) begin w_err++; w_ecyc = c; end
      if (bus.done != 0) begin w_done = bus.done; w_dcyc = c; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    tests++; if ({bus.gnt, bus.done, bus.bus_valid, bus.err} !== 10'd0) begin fails++; $display("FAIL reset_gnt_done got %b want 0", {bus.gnt, bus.done, bus.bus_valid, bus.err}); end
    tests++; if ({bus.bus_msg, bus.bus_owner} !== 5'd0) begin fails++; $display("FAIL reset_bus got %b want 0", {bus.bus_msg, bus.bus_owner}); end
    tests++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem got %b want 00", {bus.mem_req, bus.mem_we}); end
    reset_n = 1'b1;
  endtask

  task automatic test_read_miss();
    bus.req = 4'b0001; bus.req_msg = 12'b000_000_000_001; bus.req_wb = 4'b0000;
    bus.snoop_ack = 4'b1110; bus.snoop_wb = 4'b0000; bus.mem_done = 1'b1;
    watch(20);
    bus.req = 4'b0000;
    tests++; if (w_gnt !== 4'b0001) begin fails++; $display("FAIL rd_gnt got %b want 0001", w_gnt); end
    tests++; if (w_valid !== 1) begin fails++; $display("FAIL rd_valid_count got %0d want 1", w_valid); end
    tests++; if ({w_msg, w_own} !== {3'b001, 2'd0}) begin fails++; $display("FAIL rd_bus got %b want 00100", {w_msg, w_own}); end
    tests++; if (w_nmem !== 1 || w_we[0] !== 1'b0) begin fails++; $display("FAIL rd_mem got n=%0d we=%b want n=1 we=0", w_nmem, w_we[0]); end
    tests++; if (w_done !== 4'b0001 || w_dcyc !== 4) begin fails++; $display("FAIL rd_done got %b@%0d want 0001@4", w_done, w_dcyc); end
    tests++; if (w_err !== 0) begin fails++; $display("FAIL rd_err got %0d want 0", w_err); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 4'b1111; bus.req_msg = 12'b011_011_011_011; bus.snoop_ack = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      watch(12);
      tests++; if (w_done !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_order%0d got %b want %b", k, w_done, 4'(1 << (k % 4))); end
      tests++; if (w_dcyc !== (k == 0 ? 3 : 4)) begin fails++; $display("FAIL rr_cycles%0d got %0d want %0d", k, w_dcyc, k == 0 ? 3 : 4); end
      if (k > 0) begin
        tests++; if (w_first !== 4'b0000) begin fails++; $display("FAIL rr_idle_gap%0d got %b want 0000", k, w_first); end
      end
    end
    bus.req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_writebacks();
    bus.req = 4'b0100; bus.req_msg = 12'b000_010_000_000; bus.req_wb = 4'b0100;
    bus.snoop_ack = 4'b1011; bus.snoop_wb = 4'b0010; bus.mem_done = 1'b1;
    watch(20);
    bus.req = 4'b0000; bus.req_wb = 4'b0000; bus.snoop_wb = 4'b0000;
    tests++; if (w_nmem !== 3 || w_we[2:0] !== 3'b110) begin fails++; $display("FAIL wb_mem_seq got n=%0d we=%b want n=3 we=110", w_nmem, w_we[2:0]); end
    tests++; if ({w_msg, w_own} !== {3'b010, 2'd2}) begin fails++; $display("FAIL wb_bus got %b want 01010", {w_msg, w_own}); end
    tests++; if (w_done !== 4'b0100 || w_dcyc !== 6) begin fails++; $display("FAIL wb_done got %b@%0d want 0100@6", w_done, w_dcyc); end
    tests++; if (w_err !== 0) begin fails++; $display("FAIL wb_err got %0d want 0", w_err); end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    bus.req = 4'b0001; bus.req_msg = 12'b000_000_000_011; bus.snoop_ack = 4'b0110;
    watch(20);
    tests++; if (w_err !== 1 || w_ecyc !== TO + 2) begin fails++; $display("FAIL to_err got %0d@%0d want 1@%0d", w_err, w_ecyc, TO + 2); end
    tests++; if (w_done !== 4'b0001 || w_dcyc !== TO + 2) begin fails++; $display("FAIL to_done got %b@%0d want 0001@%0d", w_done, w_dcyc, TO + 2); end
    tests++; if (w_nmem !== 0) begin fails++; $display("FAIL to_mem got %0d want 0", w_nmem); end
    @(negedge clock);
    fork
      watch(20);
      begin repeat (TO + 1) @(negedge clock); bus.snoop_ack = 4'b1110; end
    join
    bus.snoop_ack = 4'b0110;
    tests++; if (w_err !== 0 || w_dcyc !== TO + 2) begin fails++; $display("FAIL to_ack_wins got err=%0d@%0d want 0@%0d", w_err, w_dcyc, TO + 2); end
    @(negedge clock);
    fork
      watch(20);
      begin @(negedge clock); bus.snoop_ack = 4'b1110; @(negedge clock); bus.snoop_ack = 4'b0110; end
    join
    bus.req = 4'b0000;
    tests++; if (w_err !== 1 || w_dcyc !== TO + 2) begin fails++; $display("FAIL bcast_ack_ignored got err=%0d@%0d want 1@%0d", w_err, w_dcyc, TO + 2); end
    @(negedge clock);
  endtask

  task automatic test_illegal();
    bus.req = 4'b0110; bus.req_msg = 12'b000_011_101_000; bus.snoop_ack = 4'b1111;
    watch(10);
    tests++; if (w_done !== 4'b0010 || w_dcyc !== 1) begin fails++; $display("FAIL ill_done got %b@%0d want 0010@1", w_done, w_dcyc); end
    tests++; if (w_valid !== 0 || w_err !== 1) begin fails++; $display("FAIL ill_err got valid=%0d err=%0d want 0 1", w_valid, w_err); end
    watch(10);
    bus.req = 4'b0000;
    tests++; if (w_done !== 4'b0100 || {w_msg, w_own} !== {3'b011, 2'd2}) begin fails++; $display("FAIL ill_next got %b bus=%b want 0100 bus=01110", w_done, {w_msg, w_own}); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001; bus.req_msg = 12'b000_000_000_001; bus.snoop_ack = 4'b1110; bus.mem_done = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if ({bus.mem_req, bus.mem_we, bus.gnt} !== 6'b10_0001) begin fails++; $display("FAIL mid_fill got %b want 100001", {bus.mem_req, bus.mem_we, bus.gnt}); end
    #1 reset_n = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL mid_mem_req got %b want 0", bus.mem_req); end
    tests++; if ({bus.gnt, bus.done, bus.bus_valid, bus.err, bus.mem_we, bus.bus_msg, bus.bus_owner} !== 17'd0) begin fails++; $display("FAIL mid_outputs got %b want 0", {bus.gnt, bus.done, bus.bus_valid, bus.err, bus.mem_we, bus.bus_msg, bus.bus_owner}); end
    @(negedge clock);
    reset_n = 1'b1; bus.mem_done = 1'b1; bus.req = 4'b1001; bus.req_msg = 12'b011_000_000_011; bus.snoop_ack = 4'b1111;
    watch(10);
    bus.req = 4'b0000;
    tests++; if (w_done !== 4'b0001 || w_dcyc !== 3) begin fails++; $display("FAIL mid_priority got %b@%0d want 0001@3", w_done, w_dcyc); end
  endtask

  initial begin
    bus.req = '0; bus.req_msg = '0; bus.req_wb = '0;
    bus.snoop_ack = '0; bus.snoop_wb = '0; bus.mem_done = 1'b0;
    test_reset();
    test_read_miss();
    test_round_robin();
    test_writebacks();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
